router_pkt_tx: RTL and testbench

ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

---
 rtl/router_pkt_tx_if.sv | 39 +++
 rtl/router_pkt_tx.sv | 238 +++++++++++++++++++++++
 tb/tb_router_pkt_tx.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/router_pkt_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : router_pkt_tx_if
// Description : Handshake and byte-stream bundle between a packet source and
//               router_pkt_tx, and from router_pkt_tx toward the router.
//               master = requester/router side, slave = router_pkt_tx.
// Ports       : req_valid/req_addr/req_len/req_ready - packet request
//               pl_valid/pl_data/pl_ready             - payload byte stream
//               data_in/pkt_valid/busy/err            - router byte interface
//               done/err_flag/bad_req                 - completion status
// Revision    : 1.0 - initial release
// ============================================================================
interface router_pkt_tx_if;
  logic       req_valid;
  logic [1:0] req_addr;
  logic [5:0] req_len;
  logic       req_ready;
  logic       pl_valid;
  logic [7:0] pl_data;
  logic       pl_ready;
  logic [7:0] data_in;
  logic       pkt_valid;
  logic       busy;
  logic       err;
  logic       done;
  logic       err_flag;
  logic       bad_req;

  modport master (
    output req_valid, req_addr, req_len, pl_valid, pl_data, busy, err,
    input  req_ready, pl_ready, data_in, pkt_valid, done, err_flag, bad_req
  );

  modport slave (
    input  req_valid, req_addr, req_len, pl_valid, pl_data, busy, err,
    output req_ready, pl_ready, data_in, pkt_valid, done, err_flag, bad_req
  );
endinterface
`default_nettype wire

// File: rtl/router_pkt_tx.sv
`default_nettype none
// ============================================================================
// Module      : router_pkt_tx
// Description : Buffers a whole packet payload, then streams header, payload
//               and an XOR parity byte to a router, honouring the router's
//               busy stall, and samples the router's err line for ERR_WAIT
//               cycles before reporting completion.
// Ports       : clock    - sole clock, rising edge
//               reset    - synchronous, active-high
//               inj_err  - (ROUTER_PKT_TX_CORRUPT_EN only) invert the parity
//                          byte of the request accepted alongside it
//               bus      - router_pkt_tx_if.slave (request, payload, router
//                          byte stream and status)
// Options     : `define ROUTER_PKT_TX_CORRUPT_EN to add the inj_err input.
// Revision    : 1.0 - initial release
// ============================================================================
module router_pkt_tx #(
  parameter int ERR_WAIT = 3,
  parameter int MAX_LEN  = 63
) (
  input  wire logic      clock,
  input  wire logic      reset,
`ifdef ROUTER_PKT_TX_CORRUPT_EN
  input  wire logic      inj_err,
`endif
  router_pkt_tx_if.slave bus
);

  localparam int WCNT_W = (ERR_WAIT > 1) ? $clog2(ERR_WAIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_HEADER   = 3'd2,
    S_PAYLOAD  = 3'd3,
    S_PARITY   = 3'd4,
    S_WAIT_ERR = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        addr_q, addr_d;
  logic [5:0]        len_q, len_d;
  logic [5:0]        ld_idx_q, ld_idx_d;
  logic [5:0]        out_idx_q, out_idx_d;
  logic [7:0]        parity_q, parity_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              inj_q, inj_d;

  logic              req_ready_q, req_ready_d;
  logic              pl_ready_q, pl_ready_d;
  logic [7:0]        data_in_q, data_in_d;
  logic              pkt_valid_q, pkt_valid_d;
  logic              done_q, done_d;
  logic              err_flag_q, err_flag_d;
  logic              bad_req_q, bad_req_d;

  logic [7:0]        pl_buf_q [0:MAX_LEN];
  logic              buf_we;
  logic [5:0]        next_idx;
  logic [7:0]        next_byte;
  logic [7:0]        hdr_byte;
  logic              req_inj;

`ifdef ROUTER_PKT_TX_CORRUPT_EN
  assign req_inj = inj_err;
`else
  assign req_inj = 1'b0;
`endif

  assign next_idx  = out_idx_q + 6'd1;
  assign next_byte = pl_buf_q[next_idx];
  assign hdr_byte  = {len_q, addr_q};

  // Outputs are all registered; each *_d is the value the port shows while
  // state_d is the current state.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    ld_idx_d    = ld_idx_q;
    out_idx_d   = out_idx_q;
    parity_d    = parity_q;
    wait_cnt_d  = wait_cnt_q;
    inj_d       = inj_q;
    data_in_d   = data_in_q;
    pkt_valid_d = pkt_valid_q;
    err_flag_d  = err_flag_q;
    done_d      = 1'b0;
    bad_req_d   = 1'b0;
    buf_we      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          addr_d     = bus.req_addr;
          len_d      = bus.req_len;
          inj_d      = req_inj;
          err_flag_d = 1'b0;
          if (bus.req_addr == 2'd3 || bus.req_len == 6'd0 ||
              {26'd0, bus.req_len} > MAX_LEN) begin
            bad_req_d = 1'b1;
          end else begin
            state_d  = S_LOAD;
            ld_idx_d = 6'd0;
          end
        end
      end

      S_LOAD: begin
        if (bus.pl_valid && pl_ready_q) begin
          buf_we = 1'b1;
          if (ld_idx_q == len_q - 6'd1) begin
            // Whole payload buffered: the stream can now run unbroken.
            state_d     = S_HEADER;
            data_in_d   = hdr_byte;
            pkt_valid_d = 1'b1;
            parity_d    = hdr_byte;
          end else begin
            ld_idx_d = ld_idx_q + 6'd1;
          end
        end
      end

      S_HEADER: begin
        if (!bus.busy) begin
          state_d   = S_PAYLOAD;
          out_idx_d = 6'd0;
          data_in_d = pl_buf_q[0];
          parity_d  = parity_q ^ pl_buf_q[0];
        end
      end

      S_PAYLOAD: begin
        if (!bus.busy) begin
          if (out_idx_q == len_q - 6'd1) begin
            // parity_q already includes the last payload byte, since each
            // byte is folded in when it is first presented.
            state_d     = S_PARITY;
            data_in_d   = parity_q ^ {8{inj_q}};
            pkt_valid_d = 1'b0;
          end else begin
            out_idx_d = next_idx;
            data_in_d = next_byte;
            parity_d  = parity_q ^ next_byte;
          end
        end
      end

      S_PARITY: begin
        if (!bus.busy) begin
          state_d    = S_WAIT_ERR;
          data_in_d  = 8'h00;
          wait_cnt_d = '0;
        end
      end

      S_WAIT_ERR: begin
        if (bus.err) begin
          err_flag_d = 1'b1;
        end
        if (wait_cnt_q == WCNT_W'(ERR_WAIT - 1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d     = S_IDLE;
        data_in_d   = 8'h00;
        pkt_valid_d = 1'b0;
      end
    endcase

    req_ready_d = (state_d == S_IDLE);
    pl_ready_d  = (state_d == S_LOAD);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= 2'd0;
      len_q       <= 6'd0;
      ld_idx_q    <= 6'd0;
      out_idx_q   <= 6'd0;
      parity_q    <= 8'h00;
      wait_cnt_q  <= '0;
      inj_q       <= 1'b0;
      req_ready_q <= 1'b0;
      pl_ready_q  <= 1'b0;
      data_in_q   <= 8'h00;
      pkt_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_flag_q  <= 1'b0;
      bad_req_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      ld_idx_q    <= ld_idx_d;
      out_idx_q   <= out_idx_d;
      parity_q    <= parity_d;
      wait_cnt_q  <= wait_cnt_d;
      inj_q       <= inj_d;
      req_ready_q <= req_ready_d;
      pl_ready_q  <= pl_ready_d;
      data_in_q   <= data_in_d;
      pkt_valid_q <= pkt_valid_d;
      done_q      <= done_d;
      err_flag_q  <= err_flag_d;
      bad_req_q   <= bad_req_d;
    end
  end

  // Payload storage carries no reset; stale contents are never read because
  // the indices restart from zero on every packet.
  always_ff @(posedge clock) begin
    if (buf_we) begin
      pl_buf_q[ld_idx_q] <= bus.pl_data;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.pl_ready  = pl_ready_q;
  assign bus.data_in   = data_in_q;
  assign bus.pkt_valid = pkt_valid_q;
  assign bus.done      = done_q;
  assign bus.err_flag  = err_flag_q;
  assign bus.bad_req   = bad_req_q;

endmodule
`default_nettype wire

// File: tb/tb_router_pkt_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_router_pkt_tx
// Description : Directed, self-checking bench for router_pkt_tx. Each packet
//               pushes its expected per-cycle router stream into a queue that
//               is popped and compared while the packet is sent.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_router_pkt_tx;

  localparam int ERR_WAIT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  router_pkt_tx_if bus_if ();

`ifdef ROUTER_PKT_TX_CORRUPT_EN
  logic inj_err = 1'b0;
`endif

  router_pkt_tx #(.ERR_WAIT(ERR_WAIT), .MAX_LEN(63)) dut (
    .clock   (clk),
    .reset   (rst),
`ifdef ROUTER_PKT_TX_CORRUPT_EN
    .inj_err (inj_err),
`endif
    .bus     (bus_if)
  );

  typedef struct {
    logic       pv;
    logic [7:0] data;
    logic       dn;
    logic       ef;
    logic       bz;
    logic       er;
  } exp_t;

  exp_t       exp_q[$];
  int         vectors     = 0;
  int         miscompares = 0;
  logic [7:0] pl [0:63];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drives one request at a negedge; returns at the negedge after acceptance.
  task automatic send_req(input logic [1:0] a, input logic [5:0] l, input logic inj);
    check("req_ready_idle", bus_if.req_ready, 1'b1);
    bus_if.req_valid = 1'b1;
    bus_if.req_addr  = a;
    bus_if.req_len   = l;
`ifdef ROUTER_PKT_TX_CORRUPT_EN
    inj_err = inj;
`else
    if (inj) $display("note: inj_err requested without corrupt option");
`endif
    @(negedge clk);
    bus_if.req_valid = 1'b0;
  endtask

  task automatic load(input int len, input bit gap);
    int   i = 0;
    int   guard = 0;
    logic rdy;
    while (i < len && guard < 4 * len + 8) begin
      bus_if.pl_valid = 1'b1;
      bus_if.pl_data  = pl[i];
      rdy = bus_if.pl_ready;
      @(negedge clk);
      guard++;
      if (rdy) begin
        i++;
        if (gap && i < len) begin
          bus_if.pl_valid = 1'b0;
          @(negedge clk);
          guard++;
        end
      end
    end
    bus_if.pl_valid = 1'b0;
    check("load_count", i, len);
  endtask

  // Byte k: 0 = header, 1..l = payload, l+1 = parity. hold_at/err_at < 0 = none.
  task automatic build_stream(input logic [1:0] a, input int l, input int hold_at,
                              input int hold_n, input int err_at, input logic inj);
    logic [7:0] hdr;
    logic [7:0] par;
    logic [7:0] b;
    exp_t       e;
    hdr = {l[5:0], a};
    par = hdr;
    for (int k = 0; k <= l; k++) if (k > 0) par = par ^ pl[k-1];
    if (inj) par = ~par;
    for (int k = 0; k <= l + 1; k++) begin
      b = (k == 0) ? hdr : (k <= l) ? pl[k-1] : par;
      for (int c = 0; c <= ((k == hold_at) ? hold_n : 0); c++) begin
        e.pv = (k <= l); e.data = b; e.dn = 1'b0; e.ef = 1'b0;
        e.bz = (k == hold_at) && (c < hold_n); e.er = 1'b0;
        exp_q.push_back(e);
      end
    end
    for (int w = 0; w < ERR_WAIT; w++) begin
      e.pv = 1'b0; e.data = 8'h00; e.dn = 1'b0; e.ef = 1'b0; e.bz = 1'b0;
      e.er = (w == err_at);
      exp_q.push_back(e);
    end
    e.pv = 1'b0; e.data = 8'h00; e.dn = 1'b1; e.ef = (err_at >= 0); e.bz = 1'b0; e.er = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic run_stream(input int max_items);
    exp_t e;
    int   n = 0;
    while (exp_q.size() > 0 && n < max_items) begin
      e = exp_q.pop_front();
      check("pkt_valid", bus_if.pkt_valid, e.pv);
      check("data_in", bus_if.data_in, e.data);
      check("done", bus_if.done, e.dn);
      if (e.dn) check("err_flag", bus_if.err_flag, e.ef);
      bus_if.busy = e.bz;
      bus_if.err  = e.er;
      @(negedge clk);
      n++;
    end
    bus_if.busy = 1'b0;
    bus_if.err  = 1'b0;
  endtask

  task automatic after_done();
    check("done_one_cycle", bus_if.done, 1'b0);
    check("req_ready_after", bus_if.req_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic seen_done;
    bus_if.req_valid = 1'b0; bus_if.req_addr = 2'd0; bus_if.req_len = 6'd0;
    bus_if.pl_valid  = 1'b0; bus_if.pl_data  = 8'h00;
    bus_if.busy      = 1'b0; bus_if.err      = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_pkt_valid", bus_if.pkt_valid, 1'b0);
    check("rst_data_in", bus_if.data_in, 8'h00);
    check("rst_req_ready", bus_if.req_ready, 1'b0);
    check("rst_pl_ready", bus_if.pl_ready, 1'b0);
    check("rst_done", bus_if.done, 1'b0);
    check("rst_err_flag", bus_if.err_flag, 1'b0);
    check("rst_bad_req", bus_if.bad_req, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Basic packet: addr 1, len 3, payload 11 22 33
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    send_req(2'd1, 6'd3, 1'b0);
    build_stream(2'd1, 3, -1, 0, -1, 1'b0);
    check("early_pkt_valid", bus_if.pkt_valid, 1'b0);
    load(3, 1'b0);
    run_stream(1000);
    after_done();

    // Same packet, busy held 4 cycles while byte 22 is on data_in
    send_req(2'd1, 6'd3, 1'b0);
    build_stream(2'd1, 3, 2, 4, -1, 1'b0);
    load(3, 1'b0);
    run_stream(1000);
    after_done();

    // Rejected requests: addr 3, then len 0
    send_req(2'd3, 6'd5, 1'b0);
    check("bad_req_pulse", bus_if.bad_req, 1'b1);
    check("bad_req_ready", bus_if.req_ready, 1'b1);
    check("bad_req_pv", bus_if.pkt_valid, 1'b0);
    @(negedge clk);
    check("bad_req_clear", bus_if.bad_req, 1'b0);
    check("bad_req_pv2", bus_if.pkt_valid, 1'b0);
    send_req(2'd0, 6'd0, 1'b0);
    check("bad_len0_pulse", bus_if.bad_req, 1'b1);
    @(negedge clk);
    check("bad_len0_pv", bus_if.pkt_valid, 1'b0);

    // Maximum length, payload offered every other cycle
    for (int i = 0; i < 63; i++) pl[i] = 8'((i * 37 + 5) & 8'hFF);
    send_req(2'd2, 6'd63, 1'b0);
    build_stream(2'd2, 63, -1, 0, -1, 1'b0);
    load(63, 1'b1);
    run_stream(1000);
    after_done();

    // err in the second WAIT_ERR cycle
    pl[0] = 8'hA5; pl[1] = 8'h3C;
    send_req(2'd0, 6'd2, 1'b0);
    build_stream(2'd0, 2, -1, 0, 1, 1'b0);
    load(2, 1'b0);
    run_stream(1000);
    after_done();
    check("err_flag_held", bus_if.err_flag, 1'b1);

    // Reset mid-payload; the new request must also clear err_flag
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    send_req(2'd1, 6'd3, 1'b0);
    check("err_flag_cleared", bus_if.err_flag, 1'b0);
    build_stream(2'd1, 3, -1, 0, -1, 1'b0);
    load(3, 1'b0);
    run_stream(2);
    rst = 1'b1;
    @(negedge clk);
    exp_q.delete();
    check("abort_pkt_valid", bus_if.pkt_valid, 1'b0);
    check("abort_data_in", bus_if.data_in, 8'h00);
    check("abort_req_ready", bus_if.req_ready, 1'b0);
    rst = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      seen_done = seen_done | bus_if.done | bus_if.pkt_valid;
    end
    check("abort_no_done", seen_done, 1'b0);
    check("abort_ready", bus_if.req_ready, 1'b1);

`ifdef ROUTER_PKT_TX_CORRUPT_EN
    // Corrupted parity: expected parity byte F2
    send_req(2'd1, 6'd3, 1'b1);
    inj_err = 1'b0;
    build_stream(2'd1, 3, -1, 0, -1, 1'b1);
    load(3, 1'b0);
    run_stream(1000);
    after_done();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
